// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump engine:
// state encodings and register-file geometry.
package regfile_dump_pkg;

    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready word stream from the dump engine to its consumer.
// The master drives the captured word and the slave accepts it.
interface regfile_dump_if;
    import regfile_dump_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump.sv
// Walks register-file indices FIRST_REG..LAST_REG through a read port
// and streams each captured word out over a valid/ready handshake.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    regfile_dump_if.master    bus,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              xfer;

    assign xfer = valid_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            raddr_q <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = READ;
                    raddr_d = FIRST_A;
                end
            end
            READ: begin
                state_d = HOLD;
                valid_d = 1'b1;
                addr_d  = raddr_q;
                data_d  = rdata;
            end
            HOLD: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    // Stop at the last index; raddr never runs past it.
                    if (addr_q == LAST_A) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        raddr_d = raddr_q + ADDR_W'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    assign raddr         = raddr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_data  = data_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed-plus-random bench for regfile_dump: full dumps under several
// consumer patterns, abort, reset mid-dump and a single-register dump.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start_a, abort_a, start_b, abort_b;
    logic [ADDR_W-1:0] raddr_a, raddr_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              busy_a, done_a, busy_b, done_b;
    logic [DATA_W-1:0] rf_a [REG_COUNT];
    logic [DATA_W-1:0] rf_b [REG_COUNT];

    int vectors     = 0;
    int miscompares = 0;

    regfile_dump_if bus_a ();
    regfile_dump_if bus_b ();

    assign rdata_a = rf_a[raddr_a];
    assign rdata_b = rf_b[raddr_b];

    regfile_dump #(.FIRST_REG(0), .LAST_REG(31)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (start_a),
        .abort (abort_a),
        .raddr (raddr_a),
        .rdata (rdata_a),
        .bus   (bus_a),
        .busy  (busy_a),
        .done  (done_a)
    );

    regfile_dump #(.FIRST_REG(5), .LAST_REG(5)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (start_b),
        .abort (abort_b),
        .raddr (raddr_b),
        .rdata (rdata_b),
        .bus   (bus_b),
        .busy  (busy_b),
        .done  (done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_valid"}, 32'(bus_a.out_valid), 0);
        chk({tag, "_addr"},  32'(bus_a.out_addr), 0);
        chk({tag, "_data"},  bus_a.out_data, 0);
        chk({tag, "_busy"},  32'(busy_a), 0);
        chk({tag, "_done"},  32'(done_a), 0);
        chk({tag, "_raddr"}, 32'(raddr_a), 0);
    endtask

    // Model: words must arrive as indices 0,1,2.. with data rf_a[index],
    // held stable while stalled, followed by exactly one done pulse.
    task automatic run_dump(input int rmode, input bit pester,
                            output int words, output int dones,
                            output int last_cyc);
        logic              pv, pr;
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        int                cyc, post;
        words = 0; dones = 0; last_cyc = -1;
        pv = 0; pr = 0; pa = '0; pd = '0; post = 0; cyc = 0;
        while (cyc < 400 && post < 3) begin
            if (rmode == 0)      bus_a.out_ready = 1'b1;
            else if (rmode == 1) bus_a.out_ready = (cyc % 4 == 0);
            else                 bus_a.out_ready = 1'($urandom_range(0, 1));
            if (pv && !pr) begin
                chk("stall_valid", 32'(bus_a.out_valid), 1);
                chk("stall_addr",  32'(bus_a.out_addr), 32'(pa));
                chk("stall_data",  bus_a.out_data, pd);
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                chk("word_in_range", 32'(words < REG_COUNT), 1);
                chk("word_addr", 32'(bus_a.out_addr), 32'(words));
                chk("word_data", bus_a.out_data, rf_a[words[4:0]]);
                words++;
                last_cyc = cyc;
            end
            if (done_a) begin
                dones++;
                chk("done_after_last", 32'(words), 32);
            end
            if (dones > 0) post++;
            pv = bus_a.out_valid; pr = bus_a.out_ready;
            pa = bus_a.out_addr;  pd = bus_a.out_data;
            start_a = (cyc == 0) || (pester && dones == 0);
            tick();
            cyc++;
        end
        start_a = 1'b0;
        bus_a.out_ready = 1'b0;
        chk("dump_finished_in_budget", 32'(post >= 3), 1);
    endtask

    // Start a dump and stall on the word at index tgt; returns whether seen.
    task automatic run_to(input int tgt, output bit found);
        int n;
        found = 0; n = 0;
        start_a = 1'b1;
        bus_a.out_ready = 1'b1;
        while (n < 100 && !found) begin
            if (bus_a.out_valid && 32'(bus_a.out_addr) == 32'(tgt)) begin
                found = 1;
                bus_a.out_ready = 1'b0;
            end else begin
                tick();
                start_a = 1'b0;
                n++;
            end
        end
    endtask

    initial begin
        int  w, d, lc;
        bit  found;
        rst = 1'b1;
        start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
        bus_a.out_ready = 0; bus_b.out_ready = 0;
        for (int i = 0; i < REG_COUNT; i++) begin
            rf_a[i] = 32'hA5A5_0000 + 32'(i);
            rf_b[i] = $urandom;
        end
        rf_b[5] = 32'hDEAD_BEEF;
        tick();
        tick();
        chk_zero_a("reset_a");
        chk("reset_b_valid", 32'(bus_b.out_valid), 0);
        chk("reset_b_busy", 32'(busy_b), 0);
        rst = 1'b0;
        tick();

        // Full dump, consumer always ready: 2 cycles per word.
        run_dump(0, 0, w, d, lc);
        chk("full_words", 32'(w), 32);
        chk("full_dones", 32'(d), 1);
        chk("full_last_xfer_cycle", 32'(lc), 64);
        chk("full_idle_busy", 32'(busy_a), 0);

        // Consumer ready one cycle in four.
        run_dump(1, 0, w, d, lc);
        chk("slow_words", 32'(w), 32);
        chk("slow_dones", 32'(d), 1);

        // Random contents, random ready, start pestering while busy.
        for (int i = 0; i < REG_COUNT; i++) rf_a[i] = $urandom;
        run_dump(2, 1, w, d, lc);
        chk("pester_words", 32'(w), 32);
        chk("pester_dones", 32'(d), 1);

        // Start and abort together in IDLE: stay idle.
        start_a = 1'b1; abort_a = 1'b1;
        tick();
        start_a = 1'b0; abort_a = 1'b0;
        chk("start_abort_busy", 32'(busy_a), 0);
        tick();
        chk("start_abort_busy2", 32'(busy_a), 0);
        chk("start_abort_valid", 32'(bus_a.out_valid), 0);

        // Abort while holding word 10.
        run_to(10, found);
        chk("abort_reached_word10", 32'(found), 1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_valid", 32'(bus_a.out_valid), 0);
        chk("abort_busy", 32'(busy_a), 0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 32'(done_a), 0);
            tick();
        end

        // Reset during word 7, then a clean dump.
        run_to(7, found);
        chk("rst_reached_word7", 32'(found), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero_a("midrst");
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_done", 32'(done_a), 0);
            tick();
        end
        for (int i = 0; i < REG_COUNT; i++) rf_a[i] = $urandom;
        run_dump(2, 0, w, d, lc);
        chk("postrst_words", 32'(w), 32);
        chk("postrst_dones", 32'(d), 1);

        // Single-register dump on the second instance.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("single_busy", 32'(busy_b), 1);
        chk("single_early_valid", 32'(bus_b.out_valid), 0);
        tick();
        chk("single_valid", 32'(bus_b.out_valid), 1);
        chk("single_addr", 32'(bus_b.out_addr), 5);
        chk("single_data", bus_b.out_data, 32'hDEAD_BEEF);
        bus_b.out_ready = 1'b1;
        tick();
        bus_b.out_ready = 1'b0;
        chk("single_valid_drop", 32'(bus_b.out_valid), 0);
        chk("single_done", 32'(done_b), 1);
        tick();
        chk("single_done_pulse", 32'(done_b), 0);
        chk("single_idle", 32'(busy_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
